// File: rtl/fan_duty_sequencer.sv
// fan_duty_sequencer: selects fan level (manual steps or filtered DHT11 auto
// mode), maps level to a duty target and soft-ramps the duty fed to the PWM.
module fan_duty_sequencer #(
  parameter int unsigned SYS_FREQ     = 125,
  parameter int unsigned N            = 12,
  parameter int unsigned RAMP_STEP_US = 1000,
  parameter int unsigned RAMP_INC     = 16,
  parameter int unsigned T_LOW        = 24,
  parameter int unsigned T_STEP       = 2
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         fan_en,
  input  logic         mode_btn,
  input  logic         step_btn,
  input  logic         stop_req,
  input  logic [7:0]   temp,
  input  logic         temp_valid,
  input  logic         temp_err,
  output logic [N-1:0] duty,
  output logic [2:0]   level,
  output logic [1:0]   mode,
  output logic         run_e,
  output logic         ramp_busy
);

  localparam int unsigned PRE_W  = (SYS_FREQ > 1) ? $clog2(SYS_FREQ) : 1;
  localparam int unsigned RAMP_W = (RAMP_STEP_US > 1) ? $clog2(RAMP_STEP_US) : 1;
  localparam int unsigned SHL    = (N >= 12) ? N - 12 : 0;
  localparam int unsigned SHR    = (N >= 12) ? 0 : 12 - N;
  localparam logic [N-1:0] INC_N = N'(RAMP_INC);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_MANUAL = 2'd1,
    S_AUTO   = 2'd2
  } state_t;

  // Level 1..7 -> 512*level+511 on a 12-bit scale, rescaled to N bits.
  function automatic logic [N-1:0] level_to_duty(input logic [2:0] lvl);
    logic [31:0] base;
    base = (lvl == 3'd0) ? 32'd0 : ((32'(lvl) << 9) + 32'd511);
    return N'((base << SHL) >> SHR);
  endfunction

  // One ramp update: move toward tgt by INC_N, landing exactly on tgt.
  function automatic logic [N-1:0] ramp_next(input logic [N-1:0] cur,
                                             input logic [N-1:0] tgt);
    logic [N-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) > INC_N) ? (cur + INC_N) : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > INC_N) ? (cur - INC_N) : tgt;
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      level_q, level_d;
  logic [N-1:0]    duty_q, duty_d;
  logic [2:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            run_e_q, ramp_busy_q;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [RAMP_W-1:0] rstep_q, rstep_d;
  logic            us_tick_c, ramp_tick_c;
  logic [8:0]      temp_ext, excess, quot;
  logic [2:0]      cand_c;

  assign duty      = duty_q;
  assign level     = level_q;
  assign mode      = state_q;
  assign run_e     = run_e_q;
  assign ramp_busy = ramp_busy_q;

  // Free-running microsecond prescaler and ramp-interval counter.
  always_comb begin
    us_tick_c   = (pre_q == PRE_W'(SYS_FREQ - 1));
    ramp_tick_c = us_tick_c && (rstep_q == RAMP_W'(RAMP_STEP_US - 1));
    pre_d       = us_tick_c ? '0 : pre_q + PRE_W'(1);
    rstep_d     = rstep_q;
    if (us_tick_c) begin
      rstep_d = ramp_tick_c ? '0 : rstep_q + RAMP_W'(1);
    end
  end

  // Auto candidate level from temperature; 9-bit math so no wrap.
  always_comb begin
    temp_ext = {1'b0, temp};
    excess   = temp_ext - 9'(T_LOW);
    quot     = excess / 9'(T_STEP);
    cand_c   = 3'd1;
    if (temp_ext > 9'(T_LOW)) begin
      cand_c = (quot >= 9'd6) ? 3'd7 : 3'(quot + 9'd1);
    end
  end

  // Next-state: event priority, level selection, auto filter and ramp.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    duty_d     = duty_q;

    if (ramp_tick_c) begin
      duty_d = ramp_next(duty_q, level_to_duty(level_q));
    end

    if (!fan_en) begin
      state_d    = S_OFF;
      level_d    = 3'd0;
      duty_d     = '0;
      pend_d     = 3'd0;
      pend_vld_d = 1'b0;
    end else if (stop_req) begin
      state_d    = S_OFF;
      level_d    = 3'd0;
      pend_d     = 3'd0;
      pend_vld_d = 1'b0;
    end else if (mode_btn) begin
      pend_d     = 3'd0;
      pend_vld_d = 1'b0;
      unique case (state_q)
        S_OFF: begin
          state_d = S_MANUAL;
          level_d = 3'd1;
        end
        S_MANUAL: state_d = S_AUTO;
        default: begin
          state_d = S_OFF;
          level_d = 3'd0;
        end
      endcase
    end else begin
      unique case (state_q)
        S_MANUAL: begin
          if (step_btn) begin
            level_d = (level_q == 3'd7) ? 3'd1 : level_q + 3'd1;
          end
        end
        S_AUTO: begin
          if (temp_err) begin
            level_d    = 3'd7;
            pend_d     = 3'd0;
            pend_vld_d = 1'b0;
          end else if (temp_valid) begin
            if (cand_c == level_q) begin
              pend_vld_d = 1'b0;
            end else if (pend_vld_q && (pend_q == cand_c)) begin
              level_d    = cand_c;
              pend_vld_d = 1'b0;
            end else begin
              pend_d     = cand_c;
              pend_vld_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_OFF;
          level_d = 3'd0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; status flags registered from next-state values.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      level_q     <= 3'd0;
      duty_q      <= '0;
      pend_q      <= 3'd0;
      pend_vld_q  <= 1'b0;
      pre_q       <= '0;
      rstep_q     <= '0;
      run_e_q     <= 1'b0;
      ramp_busy_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      duty_q      <= duty_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      pre_q       <= pre_d;
      rstep_q     <= rstep_d;
      run_e_q     <= (level_d != 3'd0) || (duty_d != '0);
      ramp_busy_q <= (duty_d != level_to_duty(level_d));
    end
  end

endmodule
